vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 63 ++++++
 tb/tb_vga_timing_gen.sv | 100 ++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider plus h/v raster counters with registered sync/blank decode.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_tick,
    output logic [15:0] frame_count
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div_cnt;
    logic [9:0]    h_nxt, v_nxt;
    logic          h_wrap, v_wrap, tick_q;
    always_comb begin
        pix_en     = en && !rst && div_cnt == DW'(CLK_DIV - 1);
        h_wrap     = hCount == 10'(H_TOTAL - 1);
        v_wrap     = vCount == 10'(V_TOTAL - 1);
        h_nxt      = h_wrap ? 10'd0 : hCount + 10'd1;
        v_nxt      = h_wrap ? (v_wrap ? 10'd0 : vCount + 10'd1) : vCount;
        frame_tick = tick_q && en;
    end
    // Sync/bright are decoded from the next counter values so they land on the same edge as the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            tick_q      <= 1'b0;
            frame_count <= '0;
        end else begin
            tick_q <= pix_en && h_wrap && v_wrap;
            if (en)
                div_cnt <= pix_en ? '0 : div_cnt + DW'(1);
            if (pix_en) begin
                hCount      <= h_nxt;
                vCount      <= v_nxt;
                hSync       <= h_nxt >= 10'(H_SYNC);
                vSync       <= v_nxt >= 10'(V_SYNC);
                bright      <= h_nxt >= 10'(H_ACT_START) && h_nxt < 10'(H_ACT_END) &&
                               v_nxt >= 10'(V_ACT_START) && v_nxt < 10'(V_ACT_END);
                frame_count <= frame_count + {15'd0, h_wrap && v_wrap};
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized enable/reset stimulus checked against an arithmetic raster model.
module tb_vga_timing_gen;
    localparam int D = 4, H = 20, HS = 3, HA0 = 5, HA1 = 17;
    localparam int V = 12, VS = 2, VA0 = 3, VA1 = 10;
    localparam int F = D * H * V;
    logic        clk = 0, rst = 1, en = 0, en1 = 1;
    logic [9:0]  hc, vc, hc1, vc1;
    logic        hs, vs, br, pe, ft, hs1, vs1, br1, pe1, ft1;
    logic [15:0] fc, fc1;
    int t = 0, t1 = 0, errors = 0, checks = 0, ticks = 0;
    bit adv = 0;

    vga_timing_gen #(.CLK_DIV(D), .H_TOTAL(H), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
                     .V_TOTAL(V), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1)) dut (
        .clk(clk), .rst(rst), .en(en), .hCount(hc), .vCount(vc), .hSync(hs), .vSync(vs),
        .bright(br), .pix_en(pe), .frame_tick(ft), .frame_count(fc));

    // One-pixel frames at one clock per pixel: every clock completes a frame, exercising the 16-bit wrap.
    vga_timing_gen #(.CLK_DIV(1), .H_TOTAL(1), .H_SYNC(1), .H_ACT_START(0), .H_ACT_END(1),
                     .V_TOTAL(1), .V_SYNC(1), .V_ACT_START(0), .V_ACT_END(1)) dut_wrap (
        .clk(clk), .rst(rst), .en(en1), .hCount(hc1), .vCount(vc1), .hSync(hs1), .vSync(vs1),
        .bright(br1), .pix_en(pe1), .frame_tick(ft1), .frame_count(fc1));

    always #5 clk = ~clk;

    // Model state: t counts enabled clock edges since reset; everything else is derived from it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t   <= 0;
            t1  <= 0;
            adv <= 0;
        end else begin
            t1  <= t1 + 1;
            adv <= en;
            if (en) t <= t + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic check_all;
        int p, h, v;
        p = t / D;
        h = p % H;
        v = (p / H) % V;
        chk("hCount", hc, h);
        chk("vCount", vc, v);
        chk("hSync", hs, h >= HS);
        chk("vSync", vs, v >= VS);
        chk("bright", br, h >= HA0 && h < HA1 && v >= VA0 && v < VA1);
        chk("pix_en", pe, en && !rst && (t % D == D - 1));
        chk("frame_tick", ft, adv && en && t > 0 && (t % F == 0));
        chk("frame_count", fc, (p / (H * V)) % 65536);
        chk("wrap_frame_count", fc1, t1 % 65536);
        chk("wrap_frame_tick", ft1, !rst && t1 > 0);
    endtask

    initial begin
        #2 check_all;
        @(negedge clk);
        rst = 0;
        en  = 1;
        repeat (2 * F + 8) begin
            @(negedge clk);
            check_all;
            ticks += int'(ft);
        end
        chk("two_frame_ticks", ticks, 2);
        chk("two_frame_count", fc, 2);
        repeat (4000) begin
            @(negedge clk);
            check_all;
            if ($urandom_range(0, 1999) == 0) begin
                #1 rst = 1;
                #1 check_all;
                @(negedge clk);
                check_all;
                rst = 0;
            end
            en = $urandom_range(0, 9) != 0;
        end
        #1 rst = 1;
        #1 check_all;
        @(negedge clk);
        rst = 0;
        en  = 1;
        repeat (65540) begin
            @(negedge clk);
            check_all;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
